// File: rtl/common_types_pkg.sv
// ---------------------------------------------------------------------------
// common_types_pkg
// Shared types for the pipeline control blocks.
//   reg_idx_t      : 5-bit architectural register index
//   hazard_state_t : hazard controller FSM states (RUN, MULDIV_WAIT)
//   CNT_W          : width of the mul/div occupancy counter
//   lat_to_load()  : converts an EX occupancy in cycles into the counter
//                    load value (the start cycle itself counts as one)
// ---------------------------------------------------------------------------
package common_types_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_WAIT = 1'b1
    } hazard_state_t;

    localparam int CNT_W = 5;

    function automatic logic [CNT_W-1:0] lat_to_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_controller_if
// Bundles every signal of the hazard controller.
//   Port  : CLK (shared pipeline clock)
//   ctrl  : modport seen from the controller (pipeline status in, stalls out)
//   tb    : modport seen from a driver/monitor (pipeline status out, stalls in)
// ---------------------------------------------------------------------------
interface hazard_controller_if (
    input logic CLK
);
    import common_types_pkg::*;

    logic     nRST;
    reg_idx_t id_rsel1;
    reg_idx_t id_rsel2;
    reg_idx_t ex_rd;
    logic     ex_memread;
    logic     ex_muldiv_start;
    logic     ex_muldiv_div;
    logic     ex_branch_taken;
    logic     dmem_req;
    logic     dmem_ready;
    logic     stall_if;
    logic     stall_id;
    logic     stall_ex;
    logic     stall_mem;
    logic     flush_id;
    logic     flush_ex;
    logic     muldiv_busy;
    logic     muldiv_done;

    modport ctrl (
        input  CLK, nRST, id_rsel1, id_rsel2, ex_rd, ex_memread,
               ex_muldiv_start, ex_muldiv_div, ex_branch_taken,
               dmem_req, dmem_ready,
        output stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, muldiv_busy, muldiv_done
    );

    modport tb (
        input  CLK, stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, muldiv_busy, muldiv_done,
        output nRST, id_rsel1, id_rsel2, ex_rd, ex_memread,
               ex_muldiv_start, ex_muldiv_div, ex_branch_taken,
               dmem_req, dmem_ready
    );

endinterface

// File: rtl/hazard_wait_counter.sv
// ---------------------------------------------------------------------------
// hazard_wait_counter
// Loadable down-counter tracking how long a mul/div still occupies EX.
// Only exists when HAZARD_MULDIV_EN is defined; without it the controller
// has no mul/div occupancy tracking at all.
//   CLK        : clock, rising edge
//   nRST       : synchronous active-low reset (count -> 0)
//   load       : load load_value (has priority over decrement)
//   load_value : value to load
//   decrement  : count down by one, saturating at zero
//   zero       : count is zero
// ---------------------------------------------------------------------------
`ifdef HAZARD_MULDIV_EN
module hazard_wait_counter
    import common_types_pkg::*;
(
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (decrement && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule
`endif

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Pipeline hazard unit: load-use interlock, data-memory wait stalls,
// taken-branch flushes and (optionally) multi-cycle mul/div occupancy of EX.
//
// Parameters
//   MUL_LAT : cycles a mul occupies EX (1..31)
//   DIV_LAT : cycles a div occupies EX (1..32)
// Configuration
//   HAZARD_MULDIV_EN : when defined, builds the RUN/MULDIV_WAIT FSM and the
//                      occupancy counter; otherwise mul/div inputs are
//                      ignored and muldiv_busy/muldiv_done stay 0.
// Ports
//   CLK, nRST                     : clock and synchronous active-low reset
//   id_rsel1, id_rsel2            : ID-stage source registers
//   ex_rd, ex_memread             : EX destination and "is a load"
//   ex_muldiv_start/_div          : EX holds a mul (div=0) or div (div=1)
//   ex_branch_taken               : EX resolved a taken branch/jump
//   dmem_req, dmem_ready          : MEM data request and its acknowledge
//   stall_if/id/ex/mem            : hold the corresponding stage register
//   flush_id/ex                   : insert a bubble into the stage register
//   muldiv_busy, muldiv_done      : FSM in MULDIV_WAIT / release pulse
// ---------------------------------------------------------------------------
module hazard_controller
    import common_types_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [4:0] id_rsel1,
    input  logic [4:0] id_rsel2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_muldiv_start,
    input  logic       ex_muldiv_div,
    input  logic       ex_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       muldiv_busy,
    output logic       muldiv_done
);

    logic load_use;
    logic md_stall;

    assign stall_mem = dmem_req && !dmem_ready;

    // r0 is hard-wired zero, so a load into it never creates a dependency.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rsel1) || (ex_rd == id_rsel2));

`ifdef HAZARD_MULDIV_EN

    localparam logic [CNT_W-1:0] MUL_LOAD = lat_to_load(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = lat_to_load(DIV_LAT);

    hazard_state_t    state;
    hazard_state_t    state_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_value;

    assign cnt_load_value = ex_muldiv_div ? DIV_LOAD : MUL_LOAD;

    hazard_wait_counter u_wait_counter (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .decrement  (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // A start seen while MEM is waiting is not accepted: the counter must
    // only begin once the pipeline behind EX can actually move again.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (ex_muldiv_start && !stall_mem) begin
                    state_next = MULDIV_WAIT;
                end
            end
            MULDIV_WAIT: begin
                if (cnt_zero) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // The start cycle itself stalls EX, so the counter is loaded with LAT-1
    // and EX is held for LAT cycles in total; the cnt==0 cycle releases it.
    // FSM-derived outputs are forced low while reset is asserted.
    always_comb begin
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        md_stall    = 1'b0;
        muldiv_busy = 1'b0;
        muldiv_done = 1'b0;
        if (nRST) begin
            case (state)
                RUN: begin
                    cnt_load = ex_muldiv_start && !stall_mem;
                    md_stall = ex_muldiv_start;
                end
                MULDIV_WAIT: begin
                    cnt_dec     = !cnt_zero;
                    md_stall    = !cnt_zero;
                    muldiv_busy = 1'b1;
                    muldiv_done = cnt_zero;
                end
                default: begin
                    md_stall = 1'b0;
                end
            endcase
        end
    end

`else

    logic unused_muldiv_inputs;
    assign unused_muldiv_inputs = ^{ex_muldiv_start, ex_muldiv_div};

    assign md_stall    = 1'b0;
    assign muldiv_busy = 1'b0;
    assign muldiv_done = 1'b0;

`endif

    assign stall_ex = stall_mem || md_stall;

    // A taken branch squashes the dependent ID instruction anyway, so the
    // load-use interlock is dropped in favour of the flush.
    assign stall_id = stall_ex || (load_use && !ex_branch_taken);
    assign stall_if = stall_id;

    // While EX is held the branch stays in EX, so the flush is simply
    // re-evaluated once the stall clears rather than being remembered.
    assign flush_ex = !stall_ex && (load_use || ex_branch_taken);
    assign flush_id = !stall_ex && ex_branch_taken;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Drives directed and random pipeline situations into hazard_controller.
// Each applied cycle pushes the outputs expected by a cycle-count based
// reference model into a queue; an independent monitor pops and compares
// on the falling clock edge. Follows HAZARD_MULDIV_EN like the design.
// ---------------------------------------------------------------------------
module tb_hazard_controller;
    import common_types_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    hazard_controller_if hif (.CLK(CLK));

    hazard_controller #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .CLK             (CLK),
        .nRST            (hif.nRST),
        .id_rsel1        (hif.id_rsel1),
        .id_rsel2        (hif.id_rsel2),
        .ex_rd           (hif.ex_rd),
        .ex_memread      (hif.ex_memread),
        .ex_muldiv_start (hif.ex_muldiv_start),
        .ex_muldiv_div   (hif.ex_muldiv_div),
        .ex_branch_taken (hif.ex_branch_taken),
        .dmem_req        (hif.dmem_req),
        .dmem_ready      (hif.dmem_ready),
        .stall_if        (hif.stall_if),
        .stall_id        (hif.stall_id),
        .stall_ex        (hif.stall_ex),
        .stall_mem       (hif.stall_mem),
        .flush_id        (hif.flush_id),
        .flush_ex        (hif.flush_ex),
        .muldiv_busy     (hif.muldiv_busy),
        .muldiv_done     (hif.muldiv_done)
    );

    typedef struct {
        logic       nrst;
        logic [4:0] rsel1;
        logic [4:0] rsel2;
        logic [4:0] rd;
        logic       memread;
        logic       start;
        logic       div;
        logic       branch;
        logic       req;
        logic       ready;
    } stim_t;

    // Expected vector: {stall_if, stall_id, stall_ex, stall_mem,
    //                   flush_id, flush_ex, muldiv_busy, muldiv_done}
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    string      out_names[8] = '{"stall_if", "stall_id", "stall_ex", "stall_mem",
                                 "flush_id", "flush_ex", "muldiv_busy", "muldiv_done"};

`ifdef HAZARD_MULDIV_EN
    // Reference: a mul/div accepted in cycle acc_cycle holds EX for cycles
    // acc_cycle .. acc_cycle+lat-1 and is released in cycle acc_cycle+lat.
    int cyc        = 0;
    int acc_cycle  = -1000;
    int acc_lat    = 1;
`endif

    function automatic stim_t idle();
        stim_t s;
        s.nrst    = 1'b1;
        s.rsel1   = 5'd0;
        s.rsel2   = 5'd0;
        s.rd      = 5'd0;
        s.memread = 1'b0;
        s.start   = 1'b0;
        s.div     = 1'b0;
        s.branch  = 1'b0;
        s.req     = 1'b0;
        s.ready   = 1'b0;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        bit mem_stall, lu, busy, done, md, sex, sid, fex, fid;
`ifdef HAZARD_MULDIV_EN
        bit wait_stall;
`endif
        @(posedge CLK);
        #1;
        hif.nRST            = s.nrst;
        hif.id_rsel1        = s.rsel1;
        hif.id_rsel2        = s.rsel2;
        hif.ex_rd           = s.rd;
        hif.ex_memread      = s.memread;
        hif.ex_muldiv_start = s.start;
        hif.ex_muldiv_div   = s.div;
        hif.ex_branch_taken = s.branch;
        hif.dmem_req        = s.req;
        hif.dmem_ready      = s.ready;

        mem_stall = s.req && !s.ready;
        lu   = s.memread && (s.rd != 5'd0) && ((s.rd == s.rsel1) || (s.rd == s.rsel2));
        busy = 1'b0;
        done = 1'b0;
        md   = 1'b0;
`ifdef HAZARD_MULDIV_EN
        wait_stall = 1'b0;
        if (s.nrst) begin
            busy       = (cyc > acc_cycle) && (cyc <= acc_cycle + acc_lat);
            wait_stall = (cyc > acc_cycle) && (cyc <  acc_cycle + acc_lat);
            done       = (cyc == acc_cycle + acc_lat);
            md         = (!busy && s.start) || wait_stall;
        end
`endif
        sex = mem_stall || md;
        sid = sex || (lu && !s.branch);
        fex = !sex && (lu || s.branch);
        fid = !sex && s.branch;
        exp_q.push_back({sid, sid, sex, mem_stall, fid, fex, busy, done});

`ifdef HAZARD_MULDIV_EN
        if (!s.nrst) begin
            acc_cycle = -1000;
        end else if (!busy && s.start && !mem_stall) begin
            acc_cycle = cyc;
            acc_lat   = s.div ? DIV_LAT : MUL_LAT;
        end
        cyc++;
`endif
    endtask

    task automatic checkOutput(input logic [7:0] expv, input logic [7:0] actv);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (actv[7-i] !== expv[7-i]) begin
                errors++;
                $display("[TB] FAIL %s actual=%0b required=%0b at %0t",
                         out_names[i], actv[7-i], expv[7-i], $time);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front(),
                            {hif.stall_if, hif.stall_id, hif.stall_ex, hif.stall_mem,
                             hif.flush_id, hif.flush_ex, hif.muldiv_busy, hif.muldiv_done});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        hif.nRST            = 1'b0;
        hif.id_rsel1        = 5'd0;
        hif.id_rsel2        = 5'd0;
        hif.ex_rd           = 5'd0;
        hif.ex_memread      = 1'b0;
        hif.ex_muldiv_start = 1'b0;
        hif.ex_muldiv_div   = 1'b0;
        hif.ex_branch_taken = 1'b0;
        hif.dmem_req        = 1'b0;
        hif.dmem_ready      = 1'b0;

        // reset, then idle
        s = idle(); s.nrst = 1'b0;
        repeat (2) applyStimulus(s);
        applyStimulus(idle());

        // load-use hit on rsel2, then the same load into r0
        s = idle(); s.memread = 1'b1; s.rd = 5'd5; s.rsel2 = 5'd5;
        applyStimulus(s);
        s.rd = 5'd0;
        applyStimulus(s);
        applyStimulus(idle());

        // mul held in EX through its release cycle
        s = idle(); s.start = 1'b1;
        repeat (MUL_LAT + 1) applyStimulus(s);
        repeat (2) applyStimulus(idle());

        // div arriving during a two-cycle memory wait
        s = idle(); s.start = 1'b1; s.div = 1'b1; s.req = 1'b1; s.ready = 1'b0;
        repeat (2) applyStimulus(s);
        s.ready = 1'b1;
        repeat (DIV_LAT + 1) applyStimulus(s);
        applyStimulus(idle());

        // taken branch held behind a memory wait
        s = idle(); s.branch = 1'b1; s.req = 1'b1; s.ready = 1'b0;
        repeat (3) applyStimulus(s);
        s.ready = 1'b1;
        applyStimulus(s);
        applyStimulus(idle());

        // taken branch together with load-use
        s = idle(); s.branch = 1'b1; s.memread = 1'b1; s.rd = 5'd7; s.rsel1 = 5'd7;
        applyStimulus(s);
        applyStimulus(idle());

        // reset in the middle of a div (count at 10), then idle
        s = idle(); s.start = 1'b1; s.div = 1'b1;
        repeat (22) applyStimulus(s);
        s = idle(); s.nrst = 1'b0;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());

        // random traffic
        for (int n = 0; n < 600; n++) begin
            s.nrst    = ($urandom_range(0, 49) != 0);
            s.rsel1   = 5'($urandom_range(0, 3));
            s.rsel2   = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 3));
            s.memread = ($urandom_range(0, 2) == 0);
            s.start   = ($urandom_range(0, 5) == 0);
            s.div     = ($urandom_range(0, 3) == 0);
            s.branch  = ($urandom_range(0, 4) == 0);
            s.req     = ($urandom_range(0, 1) == 0);
            s.ready   = ($urandom_range(0, 2) != 0);
            applyStimulus(s);
        end
        applyStimulus(idle());

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
